gpio_input_ctrl: RTL and testbench



---
 rtl/gpio_input_ctrl_pkg.sv | 30 +++
 rtl/gpio_debounce_group.sv | 59 +++++
 rtl/gpio_input_ctrl.sv | 134 +++++++++++++
 tb/tb_gpio_input_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_input_ctrl_pkg.sv
// Shared constants, register-select type and address decode for gpio_input_ctrl.
package gpio_input_ctrl_pkg;

    localparam int unsigned GROUP_W    = 8;
    localparam int unsigned NGROUPS    = 9;
    localparam int unsigned KEY_GROUP  = 8;
    localparam int unsigned DS_W       = 64;
    localparam int unsigned SYNC_W     = NGROUPS * GROUP_W;
    localparam int unsigned DIV_W      = 24;

    localparam int unsigned STATUS_OFF = 0;
    localparam int unsigned MASK_OFF   = 4;
    localparam int unsigned DIV_OFF    = 8;

    typedef enum logic [1:0] {
        REG_STATUS,
        REG_MASK,
        REG_DIV,
        REG_NONE
    } reg_sel_e;

    // Word-address decode of the register window.
    function automatic reg_sel_e reg_decode(input logic [29:0] word, input logic [29:0] base_word);
        if (word == base_word + 30'(STATUS_OFF / 4)) return REG_STATUS;
        if (word == base_word + 30'(MASK_OFF / 4))   return REG_MASK;
        if (word == base_word + 30'(DIV_OFF / 4))    return REG_DIV;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/gpio_debounce_group.sv
// Tick-based debouncer for one 8-bit input group.
//   clk, rst   : clock, synchronous active-high reset
//   tick       : debounce evaluation strobe
//   sample     : synchronised group value
//   stable     : accepted (debounced) group value, registered
//   changed_c  : combinational pulse, high in the cycle stable takes a new value
module gpio_debounce_group
    import gpio_input_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [GROUP_W-1:0] sample,
    output logic [GROUP_W-1:0] stable,
    output logic               changed_c
);

    localparam int unsigned    CNT_W   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [GROUP_W-1:0] cand_q, cand_d;
    logic [GROUP_W-1:0] stable_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Candidate tracking and acceptance; the acceptance test uses the post-update count.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = stable;
        changed_c = 1'b0;
        if (tick) begin
            if (sample != cand_q) begin
                cand_d = sample;
                cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((cnt_d == CNT_MAX) && (cand_d != stable)) begin
                stable_d  = cand_d;
                changed_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            stable <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            stable <= stable_d;
        end
    end

endmodule

// File: rtl/gpio_input_ctrl.sv
// Input conditioning for DIP switches and keys ahead of the GPIO read path:
// two-flop sync, per-group tick debounce, change status with maskable irq.
//   clk, rst   : clock, synchronous active-high reset
//   ds_raw     : 8 raw switch groups;  key_raw : raw key group (group 8)
//   ds_stable  : debounced switches;   key_stable : debounced keys
//   irq        : registered |(STATUS & MASK)
//   Addr/ByteEn/Din : bridge bus write side (any ByteEn bit = write)
//   Dout       : combinational read data for STATUS / MASK / TICK_DIV
module gpio_input_ctrl
    import gpio_input_ctrl_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV  = 25000,
    parameter int unsigned STABLE_TICKS = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h7f80
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DS_W-1:0]     ds_raw,
    input  logic [GROUP_W-1:0]  key_raw,
    output logic [DS_W-1:0]     ds_stable,
    output logic [GROUP_W-1:0]  key_stable,
    output logic                irq,
    input  logic [31:0]         Addr,
    input  logic [3:0]          ByteEn,
    input  logic [31:0]         Din,
    output logic [31:0]         Dout
);

    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    logic [SYNC_W-1:0]  sync1_q, sync2_q;
    logic [SYNC_W-1:0]  stable_all;
    logic [NGROUPS-1:0] changed_c;
    logic [NGROUPS-1:0] status_q, status_d;
    logic [NGROUPS-1:0] mask_q, mask_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0]   div_eff_c;
    logic               tick_c;
    logic               wr_c;
    logic               div_wr_c;
    reg_sel_e           sel_c;
    logic               unused_bits;

    assign unused_bits = ^{Addr[1:0], Din[31:24]};

    assign sel_c    = reg_decode(Addr[31:2], BASE_WORD);
    assign wr_c     = |ByteEn;
    assign div_wr_c = wr_c && (sel_c == REG_DIV);

    // Tick generator; a divider of 0 behaves as 1, a divider write restarts the count.
    always_comb begin
        div_eff_c  = (div_q == '0) ? DIV_W'(1) : div_q;
        tick_c     = (tick_cnt_q == div_eff_c - DIV_W'(1));
        tick_cnt_d = tick_cnt_q + DIV_W'(1);
        if (div_wr_c || tick_c) begin
            tick_cnt_d = '0;
        end
    end

    for (genvar g = 0; g < NGROUPS; g++) begin : g_group
        gpio_debounce_group #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_group (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick_c),
            .sample   (sync2_q[g*GROUP_W +: GROUP_W]),
            .stable   (stable_all[g*GROUP_W +: GROUP_W]),
            .changed_c(changed_c[g])
        );
    end

    assign ds_stable  = stable_all[DS_W-1:0];
    assign key_stable = stable_all[KEY_GROUP*GROUP_W +: GROUP_W];

    // Register writes; hardware set is applied after W1C so it wins on a collision.
    always_comb begin
        status_d = status_q;
        mask_d   = mask_q;
        div_d    = div_q;
        if (wr_c) begin
            case (sel_c)
                REG_STATUS: begin
                    if (ByteEn[0]) status_d[7:0] = status_q[7:0] & ~Din[7:0];
                    if (ByteEn[1]) status_d[8]   = status_q[8] & ~Din[8];
                end
                REG_MASK: begin
                    if (ByteEn[0]) mask_d[7:0] = Din[7:0];
                    if (ByteEn[1]) mask_d[8]   = Din[8];
                end
                REG_DIV: begin
                    if (ByteEn[0]) div_d[7:0]   = Din[7:0];
                    if (ByteEn[1]) div_d[15:8]  = Din[15:8];
                    if (ByteEn[2]) div_d[23:16] = Din[23:16];
                end
                default: ;
            endcase
        end
        status_d = status_d | changed_c;
    end

    // Read mux.
    always_comb begin
        Dout = '0;
        case (sel_c)
            REG_STATUS: Dout = 32'(status_q);
            REG_MASK:   Dout = 32'(mask_q);
            REG_DIV:    Dout = 32'(div_q);
            default:    Dout = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            irq        <= 1'b0;
        end else begin
            sync1_q    <= {key_raw, ds_raw};
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            div_q      <= div_d;
            irq        <= |(status_d & mask_d);
        end
    end

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Self-checking bench for gpio_input_ctrl: register vector table, stable-output
// scoreboard, and hand-written multi-cycle sequences.
module tb_gpio_input_ctrl;

    localparam logic [31:0] BASE = 32'h7f80;

    logic        clk;
    logic        rst;
    logic [63:0] ds_raw;
    logic [7:0]  key_raw;
    logic [63:0] ds_stable;
    logic [7:0]  key_stable;
    logic        irq;
    logic [31:0] Addr;
    logic [3:0]  ByteEn;
    logic [31:0] Din;
    logic [31:0] Dout;

    gpio_input_ctrl #(
        .DEFAULT_DIV (25000),
        .STABLE_TICKS(4),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ds_raw    (ds_raw),
        .key_raw   (key_raw),
        .ds_stable (ds_stable),
        .key_stable(key_stable),
        .irq       (irq),
        .Addr      (Addr),
        .ByteEn    (ByteEn),
        .Din       (Din),
        .Dout      (Dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [71:0] sb[$];
    logic [63:0] exp_ds = '0;
    logic [7:0]  exp_key = '0;
    logic [71:0] prev_out = '0;
    logic [71:0] mon_cur;
    logic [31:0] rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl[13];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Addr   = a;
        ByteEn = 4'b0000;
        #1;
        d = Dout;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        Addr   = a;
        ByteEn = be;
        Din    = d;
        @(negedge clk);
        ByteEn = 4'b0000;
    endtask

    task automatic expect_change(input int g, input logic [7:0] v);
        if (g == 8) exp_key = v;
        else exp_ds[g*8 +: 8] = v;
        sb.push_back({exp_key, exp_ds});
    endtask

    task automatic wait_ds(input string nm, input logic [63:0] m, input logic [63:0] v, input int limit);
        int n = 0;
        while (((ds_stable & m) != v) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 72'(ds_stable & m), 72'(v));
    endtask

    // Every change of the debounced outputs must match the next expected snapshot.
    always @(negedge clk) begin
        mon_cur = {key_stable, ds_stable};
        if (!rst && (mon_cur !== prev_out)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected %h", mon_cur, prev_out);
            end else begin
                chk("sb_output", mon_cur, sb.pop_front());
            end
        end
        prev_out = mon_cur;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{BASE + 0,  4'b0000, 32'h0,        32'h0};
        tbl[1]  = '{BASE + 4,  4'b0000, 32'h0,        32'h0};
        tbl[2]  = '{BASE + 8,  4'b0000, 32'h0,        32'd25000};
        tbl[3]  = '{BASE + 12, 4'b0000, 32'h0,        32'h0};
        tbl[4]  = '{BASE + 12, 4'b1111, 32'hFFFFFFFF, 32'h0};
        tbl[5]  = '{BASE + 4,  4'b0000, 32'h0,        32'h0};
        tbl[6]  = '{BASE + 4,  4'b0001, 32'hFFFFFFFF, 32'h0};
        tbl[7]  = '{BASE + 4,  4'b0000, 32'h0,        32'h0FF};
        tbl[8]  = '{BASE + 4,  4'b1111, 32'hFFFFFFFF, 32'h0};
        tbl[9]  = '{BASE + 4,  4'b0000, 32'h0,        32'h1FF};
        tbl[10] = '{BASE + 8,  4'b1111, 32'hFF000004, 32'h0};
        tbl[11] = '{BASE + 8,  4'b0000, 32'h0,        32'h4};
        tbl[12] = '{BASE + 0,  4'b0000, 32'h0,        32'h0};

        rst = 1'b1; ds_raw = '0; key_raw = '0;
        Addr = '0; ByteEn = '0; Din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        chk("rst_irq", 72'(irq), 72'h0);
        chk("rst_ds_stable", 72'(ds_stable), 72'h0);
        chk("rst_key_stable", 72'(key_stable), 72'h0);

        // Register vectors: reset values, masking, byte lanes, foreign address
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            Addr   = tbl[i].addr;
            ByteEn = tbl[i].be;
            Din    = tbl[i].din;
            if (tbl[i].be == 4'b0000) begin
                #1;
                chk($sformatf("reg_vec[%0d]", i), 72'(Dout), 72'(tbl[i].exp));
            end
        end
        @(negedge clk);
        ByteEn = 4'b0000;

        // 2: group 0 debounces to A5
        @(negedge clk);
        ds_raw[7:0] = 8'hA5;
        expect_change(0, 8'hA5);
        wait_ds("t2_ds_a5", 64'hFF, 64'hA5, 22);
        @(negedge clk);
        chk("t2_irq", 72'(irq), 72'h1);
        rd(BASE + 0, rdata);
        chk("t2_status", 72'(rdata), 72'h001);

        // 3: two-tick key glitch is rejected
        @(negedge clk);
        key_raw = 8'h01;
        repeat (8) @(negedge clk);
        key_raw = 8'h00;
        repeat (30) @(negedge clk);
        chk("t3_key_stable", 72'(key_stable), 72'h0);
        rd(BASE + 0, rdata);
        chk("t3_status", 72'(rdata), 72'h001);
        chk("t3_irq", 72'(irq), 72'h1);

        // 4a: W1C clears STATUS and irq
        wr(BASE + 0, 4'b0001, 32'h1);
        chk("t4_irq_clr", 72'(irq), 72'h0);
        rd(BASE + 0, rdata);
        chk("t4_status_clr", 72'(rdata), 72'h0);

        // 4b: group-3 set lands on the W1C cycle; phase fixed by a divider write
        @(negedge clk);
        Addr = BASE + 8; ByteEn = 4'b0111; Din = 32'h4;
        ds_raw[31:24] = 8'h3C;
        expect_change(3, 8'h3C);
        @(negedge clk);
        ByteEn = 4'b0000;
        repeat (15) @(negedge clk);
        Addr = BASE + 0; ByteEn = 4'b0001; Din = 32'h8;
        @(negedge clk);
        ByteEn = 4'b0000;
        chk("t4_ds_3c", 72'(ds_stable[31:24]), 72'h3C);
        rd(BASE + 0, rdata);
        chk("t4_status_survives", 72'(rdata), 72'h008);
        chk("t4_irq_set", 72'(irq), 72'h1);
        wr(BASE + 0, 4'b0011, 32'h1FF);

        // 5: masked change, then unmask
        wr(BASE + 4, 4'b0011, 32'h0);
        @(negedge clk);
        ds_raw[47:40] = 8'hFF;
        expect_change(5, 8'hFF);
        wait_ds("t5_ds_ff", 64'hFF << 40, 64'hFF << 40, 30);
        @(negedge clk);
        rd(BASE + 0, rdata);
        chk("t5_status", 72'(rdata), 72'h020);
        chk("t5_irq_masked", 72'(irq), 72'h0);
        wr(BASE + 4, 4'b0011, 32'h020);
        chk("t5_irq_unmasked", 72'(irq), 72'h1);

        // 6: divider 0 ticks every cycle
        wr(BASE + 8, 4'b0111, 32'h0);
        @(negedge clk);
        ds_raw[15:8] = 8'h5A;
        expect_change(1, 8'h5A);
        wait_ds("t6_ds_5a", 64'hFF << 8, 64'h5A << 8, 7);

        // 6: reset in the middle of a debounce
        @(negedge clk);
        ds_raw[23:16] = 8'h77;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ds_raw = '0; key_raw = '0;
        exp_ds = '0; exp_key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_irq", 72'(irq), 72'h0);
        chk("t6_rst_ds", 72'(ds_stable), 72'h0);
        chk("t6_rst_key", 72'(key_stable), 72'h0);
        rd(BASE + 0, rdata);
        chk("t6_rst_status", 72'(rdata), 72'h0);
        rd(BASE + 4, rdata);
        chk("t6_rst_mask", 72'(rdata), 72'h0);
        rd(BASE + 8, rdata);
        chk("t6_rst_div", 72'(rdata), 72'd25000);
        repeat (10) @(negedge clk);
        chk("t6_post_rst_ds", 72'(ds_stable), 72'h0);
        chk("sb_empty", 72'(sb.size()), 72'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
